// File: rtl/key_input_pkg.sv
// Shared constants for the front-panel key input block: event field layout and width helper.
package key_input_pkg;

  localparam int unsigned NUM_KEYS   = 4;
  localparam int unsigned KEY_W      = 2;
  localparam int unsigned EV_W       = 4;
  localparam int unsigned EV_REPEAT  = 3;
  localparam int unsigned EV_PRESS   = 2;
  localparam int unsigned EV_KEY_LSB = 0;
  localparam int unsigned EV_KEY_MSB = 1;

  // Bits needed for a counter that spans 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One button: two-flop synchroniser, debounce counter, stable level and a one-cycle change pulse.
// With AUTOREPEAT_EN defined, a held key also emits periodic repeat pulses.
module key_debounce
  import key_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 120000
`ifdef AUTOREPEAT_EN
  , parameter int unsigned REPEAT_DELAY  = 6000000
  , parameter int unsigned REPEAT_PERIOD = 1200000
`endif
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic level_o,
  output logic chg_o,
  output logic press_o,
  output logic rpt_o
);

  localparam int unsigned DB_W = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            stable_q, stable_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            chg_q, chg_d;
  logic            press_q, press_d;

`ifdef AUTOREPEAT_EN
  localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RP_W   = cnt_w(RP_MAX);

  logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic            rep_first_q, rep_first_d;
  logic            rpt_q, rpt_d;
  logic [RP_W-1:0] rep_last;
`endif

  always_comb begin
    sync1_d  = ~key_ni;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    chg_d    = 1'b0;
    press_d  = press_q;
`ifdef AUTOREPEAT_EN
    rpt_d       = rpt_q;
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    rep_last    = rep_first_q ? RP_W'(REPEAT_DELAY - 1) : RP_W'(REPEAT_PERIOD - 1);
`endif

    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      chg_d    = 1'b1;
      press_d  = sync2_q;
`ifdef AUTOREPEAT_EN
      rpt_d    = 1'b0;
`endif
    end else begin
      cnt_d = cnt_q + DB_W'(1);
    end

`ifdef AUTOREPEAT_EN
    // Repeat timer runs only while the accepted level is pressed; a level change restarts it.
    if (!stable_q || chg_d) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b1;
    end else if (rep_cnt_q == rep_last) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b0;
      chg_d       = 1'b1;
      press_d     = 1'b1;
      rpt_d       = 1'b1;
    end else begin
      rep_cnt_d = rep_cnt_q + RP_W'(1);
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      stable_q    <= 1'b0;
      cnt_q       <= '0;
      chg_q       <= 1'b0;
      press_q     <= 1'b0;
`ifdef AUTOREPEAT_EN
      rpt_q       <= 1'b0;
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
`endif
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      stable_q    <= stable_d;
      cnt_q       <= cnt_d;
      chg_q       <= chg_d;
      press_q     <= press_d;
`ifdef AUTOREPEAT_EN
      rpt_q       <= rpt_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
`endif
    end
  end

  assign level_o = stable_q;
  assign chg_o   = chg_q;
  assign press_o = press_q;
`ifdef AUTOREPEAT_EN
  assign rpt_o   = rpt_q;
`else
  assign rpt_o   = 1'b0;
`endif

endmodule

// File: rtl/key_input.sv
// iceFUN push-button front end: per-key debounce, lowest-index arbiter, event FIFO, sticky overflow.
// Optional auto-repeat of held keys is compiled in with AUTOREPEAT_EN.
module key_input
  import key_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned FIFO_DEPTH      = 4
`ifdef AUTOREPEAT_EN
  , parameter int unsigned REPEAT_DELAY  = 6000000
  , parameter int unsigned REPEAT_PERIOD = 1200000
`endif
) (
  input  logic                clk12MHz,
  input  logic                rst_n,
  input  logic                key1,
  input  logic                key2,
  input  logic                key3,
  input  logic                key4,
  output logic [NUM_KEYS-1:0] keys_state,
  output logic                ev_valid,
  output logic [EV_W-1:0]     ev_data,
  input  logic                ev_ready,
  output logic                overflow,
  input  logic                ovf_clr
);

  localparam int unsigned PTR_W = cnt_w(FIFO_DEPTH);
  localparam int unsigned CNT_W = cnt_w(FIFO_DEPTH + 1);

  logic [NUM_KEYS-1:0] key_n;
  logic [NUM_KEYS-1:0] level, chg, press, rpt;

  assign key_n = {key4, key3, key2, key1};

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef AUTOREPEAT_EN
      , .REPEAT_DELAY (REPEAT_DELAY)
      , .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
    ) u_deb (
      .clk_i  (clk12MHz),
      .rst_ni (rst_n),
      .key_ni (key_n[g]),
      .level_o(level[g]),
      .chg_o  (chg[g]),
      .press_o(press[g]),
      .rpt_o  (rpt[g])
    );
  end

  logic [NUM_KEYS-1:0] pend_q, pend_d;
  logic [EV_W-1:0]     mem_q [FIFO_DEPTH];
  logic [EV_W-1:0]     mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                valid_q, valid_d;
  logic [EV_W-1:0]     data_q, data_d;
  logic                ovf_q, ovf_d;

  logic [NUM_KEYS-1:0] req, grant;
  logic [KEY_W-1:0]    gnt_idx;
  logic                found, pop, full, push_ok, drop;
  logic [EV_W-1:0]     push_ev;

  always_comb begin
    req     = pend_q | chg;
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (req[i] && !found) begin
        found    = 1'b1;
        gnt_idx  = KEY_W'(i);
        grant[i] = 1'b1;
      end
    end
    // The pending tag lives in the debounce instance and holds until its next change pulse.
    pend_d                          = req & ~grant;
    push_ev                         = '0;
    push_ev[EV_REPEAT]              = rpt[gnt_idx];
    push_ev[EV_PRESS]               = press[gnt_idx];
    push_ev[EV_KEY_MSB:EV_KEY_LSB]  = gnt_idx;

    pop     = valid_q & ev_ready;
    full    = (count_q == CNT_W'(FIFO_DEPTH));
    push_ok = found & (~full | pop);
    drop    = found & full & ~pop;

    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push_ok) begin
      mem_d[wr_q] = push_ev;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_d = rd_q + PTR_W'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    valid_d = (count_d != '0);
    data_d  = valid_d ? mem_d[rd_d] : data_q;
    ovf_d   = drop | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk12MHz or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk12MHz) begin
    mem_q <= mem_d;
  end

  assign keys_state = level;
  assign ev_valid   = valid_q;
  assign ev_data    = data_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_key_input.sv
// Self-checking bench for key_input: directed scenarios plus randomized buttons against a queue model.
module tb_key_input;

  localparam int D     = 8;
  localparam int DEPTH = 4;
`ifdef AUTOREPEAT_EN
  localparam int RD = 40;
  localparam int RP = 16;
`endif

  logic       clk = 1'b0;
  logic       rst_n, key1, key2, key3, key4, ev_ready, ovf_clr;
  logic [3:0] keys_state, ev_data;
  logic       ev_valid, overflow;

  always #5 clk = ~clk;

  key_input #(
    .DEBOUNCE_CYCLES(D),
    .FIFO_DEPTH     (DEPTH)
`ifdef AUTOREPEAT_EN
    , .REPEAT_DELAY (RD)
    , .REPEAT_PERIOD(RP)
`endif
  ) dut (
    .clk12MHz  (clk),
    .rst_n     (rst_n),
    .key1      (key1),
    .key2      (key2),
    .key3      (key3),
    .key4      (key4),
    .keys_state(keys_state),
    .ev_valid  (ev_valid),
    .ev_data   (ev_data),
    .ev_ready  (ev_ready),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  int checks = 0;
  int failures = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_stable [4];
  int         m_age    [4];
  logic [2:0] m_raw    [4];
  logic [D-1:0] m_win  [4];
  bit         m_pend   [4];
  bit         m_tpress [4];
  bit         m_trpt   [4];
`ifdef AUTOREPEAT_EN
  int         m_held   [4];
`endif
  logic [3:0] m_q [$];
  bit         m_ovf;

  function automatic logic [3:0] m_state();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_stable[i];
    return v;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_stable[i] = 0; m_age[i] = 0; m_raw[i] = '0; m_win[i] = '0;
        m_pend[i] = 0; m_tpress[i] = 0; m_trpt[i] = 0;
`ifdef AUTOREPEAT_EN
        m_held[i] = 0;
`endif
      end
      m_q.delete();
      m_ovf = 0;
    end else begin
      logic [3:0] pins;
      bit popped, full, drop, flip, s;
      int k;
      pins   = {key4, key3, key2, key1};
      full   = (m_q.size() == DEPTH);
      popped = 0;
      drop   = 0;
      if (m_q.size() > 0 && ev_ready) begin
        void'(m_q.pop_front());
        popped = 1;
      end
      k = -1;
      for (int i = 0; i < 4; i++) if (m_pend[i] && k < 0) k = i;
      if (k >= 0) begin
        m_pend[k] = 0;
        if (!full || popped) m_q.push_back({m_trpt[k], m_tpress[k], 2'(k)});
        else drop = 1;
      end
      if (drop) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;

      for (int i = 0; i < 4; i++) begin
        m_raw[i] = {m_raw[i][1:0], ~pins[i]};
        s = m_raw[i][2];
        m_win[i] = {m_win[i][D-2:0], s};
        if (m_age[i] < D) m_age[i]++;
        flip = (m_age[i] >= D) && (m_win[i] == {D{~m_stable[i]}});
        if (flip) begin
          m_stable[i] = ~m_stable[i];
          m_age[i]    = 0;
          m_pend[i]   = 1;
          m_tpress[i] = m_stable[i];
          m_trpt[i]   = 0;
`ifdef AUTOREPEAT_EN
          m_held[i]   = 0;
        end else if (m_stable[i]) begin
          m_held[i]++;
          if (m_held[i] == RD || (m_held[i] > RD && (m_held[i] - RD) % RP == 0)) begin
            m_pend[i]   = 1;
            m_tpress[i] = 1;
            m_trpt[i]   = 1;
          end
`endif
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      cmp("keys_state", keys_state, m_state());
      cmp("ev_valid", ev_valid, (m_q.size() > 0));
      if (m_q.size() > 0) cmp("ev_data", ev_data, m_q[0]);
      cmp("overflow", overflow, m_ovf);
    end
  end

  // ---------------- stimulus ----------------
  int         hold_left [4];
  logic [3:0] rpins;
  int         rdy_pct;
  bit         seen;
  logic [3:0] exp4 [4];
`ifdef AUTOREPEAT_EN
  int         t_ev [$];
  logic [3:0] d_ev [$];
  int         t_exp [6];
  logic [3:0] d_exp [6];
`endif

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 0; key1 = 1; key2 = 1; key3 = 1; key4 = 1; ev_ready = 0; ovf_clr = 0;
    cyc(3);
    cmp("rst_keys_state", keys_state, 4'h0);
    cmp("rst_ev_valid", ev_valid, 1'b0);
    cmp("rst_ev_data", ev_data, 4'h0);
    cmp("rst_overflow", overflow, 1'b0);
    rst_n = 1;
    cyc(12);

    // 1: key2 held 20 cycles
    key2 = 0;
    cyc(9);  cmp("t1_state_c9", keys_state, 4'b0000);
    cyc(1);  cmp("t1_state_c10", keys_state, 4'b0010);
    cyc(1);  cmp("t1_valid", ev_valid, 1'b1); cmp("t1_press", ev_data, 4'b0101);
    ev_ready = 1;
    cyc(1);  cmp("t1_popped", ev_valid, 1'b0);
    cyc(8);  key2 = 1;
    cyc(9);  cmp("t1_rel_c9", keys_state, 4'b0010);
    cyc(1);  cmp("t1_rel_c10", keys_state, 4'b0000);
    cyc(1);  cmp("t1_rel_valid", ev_valid, 1'b1); cmp("t1_release", ev_data, 4'b0001);
    cyc(10);

    // 2: 5-cycle glitch on key3
    key3 = 0; cyc(5); key3 = 1;
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (ev_valid || keys_state != 4'b0000) seen = 1;
    end
    cmp("t2_glitch_ignored", seen, 1'b0);

    // 3: key1 and key4 together
    key1 = 0; key4 = 0;
    cyc(11); cmp("t3_first", ev_data, 4'b0100);
    cyc(1);  cmp("t3_second", ev_data, 4'b0111);
    key1 = 1; key4 = 1;
    cyc(30);

    // 4: six events with no consumer
    ev_ready = 0;
    for (int e = 0; e < 6; e++) begin
      key1 = ~key1;
      cyc(12);
    end
    cyc(12);
    cmp("t4_overflow", overflow, 1'b1);
    exp4[0] = 4'b0100; exp4[1] = 4'b0000; exp4[2] = 4'b0100; exp4[3] = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      cmp("t4_drain_valid", ev_valid, 1'b1);
      cmp("t4_drain_data", ev_data, exp4[n]);
      ev_ready = 1;
      cyc(1);
    end
    cmp("t4_empty", ev_valid, 1'b0);
    ev_ready = 0;
    cmp("t4_ovf_sticky", overflow, 1'b1);
    ovf_clr = 1; cyc(1); ovf_clr = 0;
    cmp("t4_ovf_cleared", overflow, 1'b0);

    // 5: asynchronous reset with key2 held and events queued
    key1 = 0; key2 = 0;
    cyc(14);
    key1 = 1;
    cyc(3);
    @(posedge clk); #2; rst_n = 0; #1;
    cmp("t5_async_keys", keys_state, 4'h0);
    cmp("t5_async_valid", ev_valid, 1'b0);
    cmp("t5_async_data", ev_data, 4'h0);
    cmp("t5_async_ovf", overflow, 1'b0);
    cyc(2);
    rst_n = 1;
    cyc(9);  cmp("t5_state_c9", keys_state, 4'b0000);
    cyc(1);  cmp("t5_state_c10", keys_state, 4'b0010);
    cyc(1);  cmp("t5_press", ev_data, 4'b0101); cmp("t5_valid", ev_valid, 1'b1);
    key2 = 1; ev_ready = 1;
    cyc(30);

    // Randomized buttons, consumer and overflow clears
    rpins = 4'hF;
    rdy_pct = 50;
    for (int i = 0; i < 4; i++) hold_left[i] = int'($urandom_range(1, 30));
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (hold_left[i] == 0) begin
          rpins[i] = ~rpins[i];
          hold_left[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7))
                                                     : int'($urandom_range(10, 40));
        end else begin
          hold_left[i]--;
        end
      end
      {key4, key3, key2, key1} = rpins;
      if (c % 200 == 0) rdy_pct = int'($urandom_range(0, 100));
      ev_ready = (int'($urandom_range(0, 99)) < rdy_pct);
      ovf_clr  = ($urandom_range(0, 19) == 0);
    end
    {key4, key3, key2, key1} = 4'hF;
    ev_ready = 1; ovf_clr = 0;
    cyc(60);
    cmp("rand_drained", ev_valid, 1'b0);

`ifdef AUTOREPEAT_EN
    // 6: key1 held 100 cycles with auto-repeat
    t_exp[0] = 11; t_exp[1] = 51; t_exp[2] = 67; t_exp[3] = 83; t_exp[4] = 99; t_exp[5] = 111;
    d_exp[0] = 4'b0100; d_exp[1] = 4'b1100; d_exp[2] = 4'b1100;
    d_exp[3] = 4'b1100; d_exp[4] = 4'b1100; d_exp[5] = 4'b0000;
    key1 = 0;
    for (int c = 1; c <= 140; c++) begin
      @(negedge clk);
      if (c == 100) key1 = 1;
      if (ev_valid) begin
        t_ev.push_back(c);
        d_ev.push_back(ev_data);
      end
    end
    cmp("t6_event_count", t_ev.size(), 6);
    for (int n = 0; n < 6; n++) begin
      if (n < t_ev.size()) begin
        cmp("t6_event_time", t_ev[n], t_exp[n]);
        cmp("t6_event_data", d_ev[n], d_exp[n]);
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
